// File: rtl/upower_multicycle_sequencer.sv
// Multi-cycle Moore control sequencer for the uPOWER datapath: steps each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and counts retirements.
module upower_multicycle_sequencer #(
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instruction,
    input  logic             zero_flag,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic             RegDst,
    output logic             reg1,
    output logic             reg2,
    output logic [3:0]       ALU_OP,
    output logic [2:0]       state,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    logic [5:0] opcode;
    logic [9:0] xo;
    logic       dec_valid, is_branch, is_beq, is_ld, is_std, halt_hit;
    logic       dec_regdst, dec_reg1, dec_reg2, dec_alusrc, dec_memtoreg;
    logic [3:0] dec_aluop;
    logic       in_instr, last_state;

    assign opcode = ir_q[31:26];
    assign xo     = ir_q[10:1];

    always_comb begin
        dec_valid    = 1'b0;
        is_branch    = 1'b0;
        is_beq       = 1'b0;
        is_ld        = 1'b0;
        is_std       = 1'b0;
        dec_regdst   = 1'b0;
        dec_reg1     = 1'b0;
        dec_reg2     = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_aluop    = 4'b0000;
        case (opcode)
            6'd14: begin
                dec_valid = 1'b1; dec_reg1 = 1'b1; dec_alusrc = 1'b1; dec_aluop = 4'b0010;
            end
            6'd24: begin
                dec_valid = 1'b1; dec_regdst = 1'b1; dec_alusrc = 1'b1; dec_aluop = 4'b0001;
            end
            6'd28: begin
                dec_valid = 1'b1; dec_regdst = 1'b1; dec_alusrc = 1'b1; dec_aluop = 4'b0000;
            end
            6'd31: begin
                if (xo == 10'd266) begin
                    dec_valid = 1'b1; dec_reg1 = 1'b1; dec_reg2 = 1'b1; dec_aluop = 4'b0010;
                end else if (xo == 10'd28) begin
                    dec_valid = 1'b1; dec_regdst = 1'b1; dec_reg2 = 1'b1; dec_aluop = 4'b0000;
                end
            end
            6'd58: begin
                dec_valid = 1'b1; is_ld = 1'b1; dec_reg1 = 1'b1; dec_alusrc = 1'b1;
                dec_memtoreg = 1'b1; dec_aluop = 4'b0010;
            end
            6'd62: begin
                dec_valid = 1'b1; is_std = 1'b1; dec_reg1 = 1'b1; dec_alusrc = 1'b1;
                dec_aluop = 4'b0010;
            end
            6'd19, 6'd20: begin
                dec_valid = 1'b1; is_branch = 1'b1; is_beq = (opcode == 6'd19);
                dec_reg2 = 1'b1; dec_aluop = 4'b0110;
            end
            default: ;
        endcase
    end

    assign halt_hit = (ir_q == HALT_WORD) || !dec_valid;

    // Selects are live from DECODE through the final state of the path.
    assign in_instr   = (state_q >= S_DECODE) && (state_q <= S_WB);
    assign last_state = (state_q == S_WB)
                     || (state_q == S_MEM && is_std)
                     || (state_q == S_EXECUTE && is_branch);

    always_comb begin
        ir_write = (state_q == S_FETCH);
        pc_write = last_state;
        pc_src   = (state_q == S_EXECUTE) && is_branch && (is_beq ? zero_flag : !zero_flag);
        RegWrite = (state_q == S_WB);
        MemRead  = (state_q == S_MEM) && is_ld;
        MemWrite = (state_q == S_MEM) && is_std;
        MemToReg = in_instr && dec_memtoreg;
        ALUSrc   = in_instr && dec_alusrc;
        RegDst   = in_instr && dec_regdst;
        reg1     = in_instr && dec_reg1;
        reg2     = in_instr && dec_reg2;
        ALU_OP   = in_instr ? dec_aluop : 4'b0000;
        state    = state_q;
        busy     = (state_q >= S_FETCH) && (state_q <= S_WB);
        halted   = (state_q == S_HALT);
        illegal  = illegal_q;
        retired  = retired_q;
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        retired_d = last_state ? retired_q + CNT_W'(1) : retired_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (halt_hit) begin
                    state_d   = S_HALT;
                    illegal_d = (ir_q != HALT_WORD);
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_branch)           state_d = S_FETCH;
                else if (is_ld || is_std) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM:     state_d = is_std ? S_FETCH : S_WB;
            S_WB:      state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_upower_multicycle_sequencer.sv
// Directed bench for upower_multicycle_sequencer: a table of instructions with
// expected per-cycle paths and controls, plus halt/illegal/reset sequences.
module tb_upower_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instruction = '0;
    logic        zero_flag = 1'b0;
    logic        ir_write, pc_write, pc_src, RegWrite, MemRead, MemWrite;
    logic        MemToReg, ALUSrc, RegDst, reg1, reg2;
    logic [3:0]  ALU_OP;
    logic [2:0]  state;
    logic        busy, halted, illegal;
    logic [31:0] retired;

    upower_multicycle_sequencer #(.CNT_W(32), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .zero_flag(zero_flag), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
        .RegDst(RegDst), .reg1(reg1), .reg2(reg2), .ALU_OP(ALU_OP),
        .state(state), .busy(busy), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // {retired, state, ir_write, pc_write, pc_src, RegWrite, MemRead, MemWrite,
    //  MemToReg, ALUSrc, RegDst, reg1, reg2, ALU_OP, busy, halted, illegal}
    logic [52:0] dut_vec;
    assign dut_vec = {retired, state, ir_write, pc_write, pc_src, RegWrite, MemRead,
                      MemWrite, MemToReg, ALUSrc, RegDst, reg1, reg2, ALU_OP,
                      busy, halted, illegal};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_ret  = '0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        int unsigned len;
        logic [14:0] path;   // state of cycle i at [3*i +: 3]
        logic        mr;
        logic        mw;
        logic        pcs;
        logic [4:0]  sel;    // {MemToReg, ALUSrc, RegDst, reg1, reg2}
        logic [3:0]  op;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [52:0] mk(input logic [2:0] st, input logic ir_w, input logic pc_w,
                                       input logic pcs, input logic rw, input logic mr,
                                       input logic mw, input logic [4:0] sel, input logic [3:0] op,
                                       input logic ill, input logic [31:0] ret);
        logic bsy, hlt;
        bsy = (st >= 3'd1) && (st <= 3'd5);
        hlt = (st == 3'd6);
        return {ret, st, ir_w, pc_w, pcs, rw, mr, mw, sel, op, bsy, hlt, ill};
    endfunction

    task automatic check(input string name, input logic [52:0] exp);
        n_checks++;
        if (dut_vec === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, dut_vec, exp, $time);
    endtask

    task automatic step_check(input string name, input logic [52:0] exp);
        @(posedge clk);
        @(negedge clk);
        check(name, exp);
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr, input logic zero,
                           input int unsigned len, input logic [14:0] path, input logic mr,
                           input logic mw, input logic pcs, input logic [4:0] sel,
                           input logic [3:0] op);
        vec_t v;
        v.name = name; v.instr = instr; v.zero = zero; v.len = len; v.path = path;
        v.mr = mr; v.mw = mw; v.pcs = pcs; v.sel = sel; v.op = op;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_ret = '0;
        check("reset", mk(3'd0, 0, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, 32'd0));
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [2:0] st;
        logic       last, first;
        instruction = v.instr;
        zero_flag   = v.zero;
        for (int unsigned i = 0; i < v.len; i++) begin
            st    = v.path[3*i +: 3];
            first = (i == 0);
            last  = (i == v.len - 1);
            step_check(v.name, mk(st, first, last, last & v.pcs, st == 3'd5,
                                  (st == 3'd4) & v.mr, (st == 3'd4) & v.mw,
                                  first ? 5'b0 : v.sel, first ? 4'b0 : v.op, 1'b0, exp_ret));
        end
        exp_ret = exp_ret + 32'd1;
    endtask

    localparam logic [14:0] P_RI  = {3'd0, 3'd5, 3'd3, 3'd2, 3'd1};
    localparam logic [14:0] P_LD  = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [14:0] P_ST  = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [14:0] P_BR  = {3'd0, 3'd0, 3'd3, 3'd2, 3'd1};

    initial begin
        //        name     instr         z  len path  mr mw pcs sel       op
        add_vec("addi",   32'h3A200014, 0, 4, P_RI, 0, 0, 0, 5'b01010, 4'b0010);
        add_vec("ori",    32'h6041000F, 0, 4, P_RI, 0, 0, 0, 5'b01100, 4'b0001);
        add_vec("andi",   32'h70410003, 0, 4, P_RI, 0, 0, 0, 5'b01100, 4'b0000);
        add_vec("add",    32'h7C221A14, 0, 4, P_RI, 0, 0, 0, 5'b00011, 4'b0010);
        add_vec("and",    32'h7C221838, 0, 4, P_RI, 0, 0, 0, 5'b00101, 4'b0000);
        add_vec("ld",     32'hE8220004, 0, 5, P_LD, 1, 0, 0, 5'b11010, 4'b0010);
        add_vec("std",    32'hF8220008, 0, 4, P_ST, 0, 1, 0, 5'b01010, 4'b0010);
        add_vec("beq_t",  32'h4C220010, 1, 3, P_BR, 0, 0, 1, 5'b00001, 4'b0110);
        add_vec("beq_nt", 32'h4C220010, 0, 3, P_BR, 0, 0, 0, 5'b00001, 4'b0110);
        add_vec("bne_t",  32'h50220010, 0, 3, P_BR, 0, 0, 1, 5'b00001, 4'b0110);
        add_vec("bne_nt", 32'h50220010, 1, 3, P_BR, 0, 0, 0, 5'b00001, 4'b0110);

        do_reset();
        step_check("idle_no_start", mk(3'd0, 0, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, 32'd0));
        start = 1'b1;
        foreach (vecs[k]) run_vec(vecs[k]);

        // Halt word: stops after DECODE without retiring; start stays high.
        instruction = 32'hFFFF_FFFF;
        step_check("halt_fetch",  mk(3'd1, 1, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, exp_ret));
        step_check("halt_decode", mk(3'd2, 0, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, exp_ret));
        for (int i = 0; i < 3; i++)
            step_check("halt_hold", mk(3'd6, 0, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, exp_ret));

        // Illegal opcode 0: sticky illegal flag, start ignored in HALT.
        do_reset();
        start = 1'b1;
        instruction = 32'h0000_0000;
        step_check("ill_fetch",  mk(3'd1, 1, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, 32'd0));
        step_check("ill_decode", mk(3'd2, 0, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, 32'd0));
        for (int i = 0; i < 3; i++)
            step_check("ill_hold", mk(3'd6, 0, 0, 0, 0, 0, 0, 5'b0, 4'b0, 1, 32'd0));

        // Reset in the MEM cycle of a ld after one retirement.
        do_reset();
        start = 1'b1;
        run_vec(vecs[0]);
        instruction = 32'hE8220004;
        step_check("ldr_fetch",  mk(3'd1, 1, 0, 0, 0, 0, 0, 5'b0,     4'b0,    0, 32'd1));
        step_check("ldr_decode", mk(3'd2, 0, 0, 0, 0, 0, 0, 5'b11010, 4'b0010, 0, 32'd1));
        step_check("ldr_exec",   mk(3'd3, 0, 0, 0, 0, 0, 0, 5'b11010, 4'b0010, 0, 32'd1));
        step_check("ldr_mem",    mk(3'd4, 0, 0, 0, 0, 1, 0, 5'b11010, 4'b0010, 0, 32'd1));
        rst = 1'b0;
        step_check("ldr_reset",  mk(3'd0, 0, 0, 0, 0, 0, 0, 5'b0,     4'b0,    0, 32'd0));
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/upower_multicycle_sequencer.md
# upower_multicycle_sequencer

Multi-cycle control sequencer for the uPOWER load/store/R/I datapath. It replaces the single-cycle control unit's one-shot decode with a Moore state machine that steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives the datapath mux selects, write enables and ALU_OP, and controls PC/IR update timing. It also counts retired instructions and stops on the all-ones halt word or an illegal opcode.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter
- `HALT_WORD`, 32'hFFFF_FFFF, instruction value that halts the sequencer
- Reset polarity and timing are fixed: one clock, and reset is synchronous and active-low.
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  leaves IDLE; ignored in every other state
- `instruction`  in  32  instruction word from fetch memory; sampled only in FETCH
- `zero_flag`  in  1  ALU zero output; sampled only in EXECUTE of a branch
- `ir_write`  out  1  IR load strobe
- `pc_write`  out  1  PC update strobe
- `pc_src`  out  1  0 = PC+4, 1 = branch target
- `RegWrite`, `MemRead`, `MemWrite`, `MemToReg`, `ALUSrc`, `RegDst`, `reg1`, `reg2`  out  1 each  datapath controls; mux meanings as in the existing datapath
- `ALU_OP`  out  4  0010 add, 0110 sub, 0000 and, 0001 or
- `state`  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6
- `busy`  out  1  high in states FETCH through WRITEBACK
- `halted`  out  1  high in HALT
- `illegal`  out  1  sticky; set when HALT is entered through an illegal opcode
- `retired`  out  CNT_W  count of completed instructions

## Operation
- Internal register `ir_q` loads `instruction` on the FETCH edge. All decode uses `ir_q[31:26]` and, for opcode 31, `ir_q[10:1]`.
- Outputs are a combinational function of registered `state` and `ir_q`. Strobes default to 0. The select set (`RegDst`, `ALUSrc`, `reg1`, `reg2`, `MemToReg`, `ALU_OP`) is held constant from DECODE through the last state of the instruction. Outside those states every select is 0.
- Decode table, listed as RegDst, reg1, reg2, ALUSrc, ALU_OP, then path:
  - addi (14): 0, 1, 0, 1, 0010; path EX→WB
  - ori (24): 1, 0, 0, 1, 0001; path EX→WB
  - andi (28): 1, 0, 0, 1, 0000; path EX→WB
  - add (31, XO 266): 0, 1, 1, 0, 0010; path EX→WB
  - and (31, XO 28): 1, 0, 1, 0, 0000; path EX→WB
  - ld (58): 0, 1, 0, 1, 0010, MemToReg=1; path EX→MEM(MemRead)→WB
  - std (62): 0, 1, 0, 1, 0010; path EX→MEM(MemWrite)
  - beq (19) and bne (20): 0, 0, 1, 0, 0110; path EX only
- State transitions:
  - IDLE→FETCH when `start`=1.
  - FETCH→DECODE.
  - DECODE→HALT if `ir_q`==HALT_WORD or the opcode/XO is not in the decode table; otherwise DECODE→EXECUTE.
  - The last state of each path (WB, MEM for std, EXECUTE for branches) →FETCH.
- Strobes:
  - `ir_write`=1 in FETCH.
  - `RegWrite`=1 in WRITEBACK.
  - `MemRead` (ld) or `MemWrite` (std) =1 in MEM.
  - `pc_write`=1 in the last state of the path.
- `pc_src`=1 only in branch EXECUTE when taken: beq with `zero_flag`=1, or bne with `zero_flag`=0.
- `retired` increments in every cycle where `pc_write`=1. It wraps modulo 2^CNT_W.
- A halt word or illegal opcode produces no write strobe, no `pc_write`, and no `retired` increment. HALT is terminal until reset.

## Timing
- Reset (`rst`=0 at an edge) gives: state IDLE, `ir_q`=0, `retired`=0, `illegal`=0, every output 0. This holds at any point, including mid-instruction; no strobe is asserted in the cycle after reset.
- Cycles per instruction, from FETCH to the next FETCH:
  - R/I-type: 4
  - ld: 5
  - std: 4
  - branch: 3
- Branch `zero_flag` is taken combinationally in the EXECUTE cycle, with no extra latency.
- `start` held high continuously has no effect after the first FETCH.

## Test plan
- Reset: drive `rst`=0 for 2 edges. All outputs are 0 and `state`=0. Then raise `start`: FETCH follows on the next edge with `ir_write`=1.
- addi R17,R0,20 (0x3A200014): the bench sees 4 cycles in states 1,2,3,5. `RegWrite`=1 only in state 5; RegDst=0, reg1=1, ALUSrc=1, ALU_OP=0010; `retired` 0→1.
- ld R1,1(R2) (0xE8220004): 5 cycles. `MemRead`=1 only in state 4; `MemToReg`=1 in states 2–5; `RegWrite`=1 only in state 5.
- beq: with `zero_flag`=1, `pc_src`=1 and `pc_write`=1 in EXECUTE. With `zero_flag`=0, `pc_src`=0. Each case takes 3 cycles and no RegWrite/MemWrite occurs.
- Halt and illegal: 0xFFFFFFFF reaches HALT after DECODE with `halted`=1, `illegal`=0 and `retired` unchanged. Opcode 0 reaches HALT with `illegal`=1, and `start` is then ignored.
- Reset mid-ld: deassert-to-0 in MEM. The next cycle shows IDLE, `MemRead`=0, `retired`=0.
